// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and instruction-memory constants
package imem_loader_pkg;
  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = 10;
  localparam int INSTR_W     = 16;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, FINISH} state_e;
  function automatic logic rx_state(state_e s);
    return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake, memory write port and CPU status of the loader
interface imem_loader_if #(parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W);
  import imem_loader_pkg::*;
  logic               start;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;
  modport master (output start, rx_valid, rx_data,
                  input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
  modport slave  (input  start, rx_valid, rx_data,
                  output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 16-bit words written to consecutive imem addresses
module imem_loader import imem_loader_pkg::*; #(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  state_e             state_q, state_d;
  logic [15:0]        len_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] word_q;
  logic               rx_ready_q, mem_we_q, cpu_hold_q, done_q, error_q;
  logic               xfer, last, bad_len;
  logic [15:0]        len_full;
  assign xfer     = bus.rx_valid && rx_ready_q;
  assign len_full = {len_q[15:8], bus.rx_data};
  assign bad_len  = len_full > 16'(DEPTH);
  assign last     = 16'(addr_q) == len_q - 16'd1;
  // next state; receive states hold until a byte is transferred
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? LEN_HI : IDLE;
      LEN_HI:  state_d = xfer ? LEN_LO : LEN_HI;
      LEN_LO:  state_d = !xfer ? LEN_LO : len_full == 16'd0 ? FINISH : bad_len ? IDLE : DATA_HI;
      DATA_HI: state_d = xfer ? DATA_LO : DATA_HI;
      DATA_LO: state_d = xfer ? WRITE : DATA_LO;
      WRITE:   state_d = last ? FINISH : DATA_HI;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, datapath and outputs registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_state(state_d);
      mem_we_q   <= state_d == WRITE;
      cpu_hold_q <= state_d != IDLE;
      if (state_q == IDLE && bus.start) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
        addr_q  <= '0;
        len_q   <= '0;
      end
      if (state_q == FINISH) done_q <= 1'b1;
      if (state_q == LEN_HI && xfer) len_q[15:8] <= bus.rx_data;
      if (state_q == LEN_LO && xfer) begin
        len_q[7:0] <= bus.rx_data;
        error_q    <= bad_len;
      end
      if (state_q == DATA_HI && xfer) word_q[15:8] <= bus.rx_data;
      if (state_q == DATA_LO && xfer) word_q[7:0] <= bus.rx_data;
      if (state_q == WRITE && !last) addr_q <= addr_q + 1'b1;
    end
  end
  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized self-checking bench for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;
  typedef struct {
    int          n;
    int          gap;
    bit          noise;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          done;
    bit          err;
    int          hold;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          hold_total = 0;
  int          wa[$];
  logic [15:0] wd[$];
  logic [7:0]  stream[$];
  logic [15:0] exp_wd[$];
  bit          m_done, m_err;
  vec_t        vt[7];
  imem_loader_if bus();
  imem_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // observe writes and hold cycles away from the active edge
  always @(negedge clk) begin
    if (bus.cpu_hold) hold_total++;
    if (bus.mem_we) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(bus.mem_wdata);
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, bus.rx_ready, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_cpu_hold"}, bus.cpu_hold, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
  endtask
  // stream for N words: word 0 and 1 given, every later word equals its address
  function automatic void build(input int n, input logic [15:0] w0, input logic [15:0] w1);
    logic [15:0] w;
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    if (n <= IMEM_DEPTH)
      for (int i = 0; i < n; i++) begin
        w = i == 0 ? w0 : i == 1 ? w1 : 16'(i);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
      end
  endfunction
  // reference: parse the stream into the expected list of words and final flags
  function automatic void model();
    int n;
    n = int'({stream[0], stream[1]});
    m_err = n > IMEM_DEPTH;
    m_done = !m_err;
    exp_wd.delete();
    if (!m_err)
      for (int i = 0; i < n; i++) exp_wd.push_back({stream[2+2*i], stream[3+2*i]});
  endfunction
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int t;
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      bus.start = noise && $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    bus.start = noise && $urandom_range(0, 1) == 1;
    t = 0;
    while (!bus.rx_ready && t < 100) begin
      @(negedge clk);
      t++;
      bus.start = noise && $urandom_range(0, 1) == 1;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: byte %0h got ready=0, expected 1", b);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic run_load(input int gap, input bit noise, input bit e_done, input bit e_err, input int e_hold);
    int h0, w0, t;
    h0 = hold_total;
    w0 = wd.size();
    pulse_start();
    foreach (stream[i]) send_byte(stream[i], gap, noise);
    t = 0;
    while (bus.cpu_hold && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("load_finished", t < 5000, 1);
    chk("done", bus.done, e_done);
    chk("error", bus.error, e_err);
    if (e_hold >= 0) chk("hold_cycles", hold_total - h0, e_hold);
    chk("write_count", wd.size() - w0, exp_wd.size());
    foreach (exp_wd[i])
      if (w0 + i < wd.size()) begin
        chk("write_addr", wa[w0+i], i);
        chk("write_data", wd[w0+i], exp_wd[i]);
      end
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("idle_refuses_byte", bus.rx_ready, 0);
    end
    bus.rx_valid = 1'b0;
    chk("idle_no_write", wd.size() - w0, exp_wd.size());
  endtask
  initial begin
    int w0, n, gap;
    vt[0] = '{2, 0, 1'b0, 16'h2003, 16'h8000, 1'b1, 1'b0, 9};
    vt[1] = '{2, 5, 1'b1, 16'h2003, 16'h8000, 1'b1, 1'b0, -1};
    vt[2] = '{1025, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2};
    vt[3] = '{0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 3};
    vt[4] = '{1024, 0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 3075};
    vt[5] = '{3, 2, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, -1};
    vt[6] = '{65535, 1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, -1};
    bus.start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready_no_start", bus.rx_ready, 0);
    chk("idle_hold_no_start", bus.cpu_hold, 0);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      build(vt[i].n, vt[i].w0, vt[i].w1);
      model();
      run_load(vt[i].gap, vt[i].noise, vt[i].done, vt[i].err, vt[i].hold);
    end
    build(5, 16'h1111, 16'h2222);
    model();
    w0 = wd.size();
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(stream[i], 0, 1'b0);
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = stream[9];
    @(negedge clk);
    chk_reset_vals("midload_reset");
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_ready", bus.rx_ready, 0);
    end
    bus.rx_valid = 1'b0;
    chk("reset_write_count", wd.size() - w0, 3);
    for (int i = 0; i < 3; i++)
      if (w0 + i < wd.size()) chk("reset_kept_write", wd[w0+i], exp_wd[i]);
    build(1, 16'hBEEF, 16'h0000);
    model();
    run_load(0, 1'b0, 1'b1, 1'b0, 6);
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 4) == 0 ? 1025 + $urandom_range(0, 64000) : $urandom_range(0, 10);
      gap = $urandom_range(0, 3);
      stream.delete();
      stream.push_back(n[15:8]);
      stream.push_back(n[7:0]);
      if (n <= IMEM_DEPTH)
        for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
      model();
      run_load(gap, 1'b1, m_done, m_err, gap != 0 ? -1 : m_err ? 2 : 3 + 3 * n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
